alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Driving end of the core's ALU interface: decodes an RV32I/Zicsr instruction plus register-file read data into ALU operand A, operand B and a 4-bit op select.
- Presents them registered, under a valid/ready handshake, to the execute stage.
- Sits between decode/register-read and execute.
- A two-entry skid buffer gives a fully registered in_ready, so execute-stage stalls never combinationally reach the fetch path.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- ILLEGAL_SEL, 4'hF, op select emitted for undecodable instructions.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  input entry valid
- in_ready  out  1  input can be accepted (registered)
- inst_in  in  32  instruction word
- pc_in  in  32  instruction PC
- rs1_data  in  32  register-file read of inst[19:15]
- rs2_data  in  32  register-file read of inst[24:20]
- out_valid  out  1  ALU operands valid
- out_ready  in  1  execute stage accepts
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_sel  out  4  op select: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SLT=6 SLTU=7 SRA=8 SRL=9 PASS(B)=10 CSR_PASS(A)=11 none=ILLEGAL_SEL
- out_illegal  out  1  entry was undecodable
- out_rd  out  5  inst[11:7] of the entry

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, in_ready=1, alu_a=0, alu_b=0, alu_sel=ILLEGAL_SEL, out_illegal=0, out_rd=0.
  - Skid buffer empty.
- Accept and issue:
  - An input is accepted when in_valid && in_ready at a clk edge.
  - It is issued when out_valid && out_ready.
- Latency: accepted input appears on outputs the next cycle (1 cycle) when the output register is empty or draining.
- Storage:
  - Output register (main) plus one skid register.
  - in_ready next = !(skid occupied next cycle).
- Accept while main full and not draining: the entry goes to skid; in_ready drops the following cycle.
- Drain with skid occupied: skid moves to main in the same edge as the issue; in_ready returns to 1 next cycle.
- Simultaneous accept and drain with skid empty: the new entry loads main directly.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- flush:
  - Clears out_valid and the skid at the next edge; in_ready=1 next cycle.
  - An input presented in the same cycle as flush is discarded.
  - flush has priority over every other event.
- rst mid-operation: identical to flush, plus all data outputs return to their reset values.
- Decode (imm = standard sign-extended RV32I immediate):
  - OP (0110011): A=rs1, B=rs2. Sel is decoded from funct3. funct7[5]=1 selects SUB for funct3=000 and SRA for funct3=101.
  - OP-IMM (0010011): A=rs1, B=immI. funct3 001 → SLL and 101 → SRL/SRA, both with B=shamt zero-extended. funct7[5] selects SRA. There is never a SUB.
  - LOAD and STORE: ADD, A=rs1, B=immI or immS.
  - BRANCH: ADD, A=pc, B=immB.
  - JAL: ADD, A=pc, B=immJ.
  - JALR: ADD, A=rs1, B=immI.
  - LUI: PASS, A=0, B=immU.
  - AUIPC: ADD, A=pc, B=immU.
  - SYSTEM CSRRW/CSRRS/CSRRC: CSR_PASS, A=rs1, B=0.
  - SYSTEM CSRRWI/CSRRSI/CSRRCI: CSR_PASS, A=zero-extended inst[19:15], B=0.
  - Anything else (incl. instruction 0, ECALL, bad funct3): alu_sel=ILLEGAL_SEL, A=B=0, out_illegal=1.
- Data outputs hold their value while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- When defined, three extra inputs are added: fwd_valid (1), fwd_rd (5), fwd_data (32).
  - At accept, rs1_data or rs2_data is replaced by fwd_data when fwd_valid && fwd_rd!=0 && fwd_rd matches the respective source field.
  - Both sources are replaced if both match.
  - The substitution happens before operand selection.
- When undefined, the ports do not exist and rs1_data/rs2_data are used unmodified.

Test Plan:
- Reset then R-type ADD: inst 0x002081B3, rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, A=5, B=7, sel=0, out_rd=3.
- SUB and SRAI: inst 0x402081B3 → sel=1. SRAI inst 0x4030D193, rs1=0x80000000 → sel=8, B=3.
- LUI 0x123450B7 → sel=10, B=0x12345000. CSRRWI 0x34015073 → sel=11, A=2.
- Backpressure: three back-to-back instructions with out_ready=0 for 3 cycles → in_ready falls after 2 accepts; the 3rd is held upstream; release → issued in order, none lost.
- Flush with main and skid full, plus in_valid in the same cycle → out_valid=0 next cycle, in_ready=1, the flushed entries never appear.
- Illegal 0x00000000 → sel=4'hF, out_illegal=1, A=B=0. With ALU_ISSUE_BYPASS_EN: fwd_rd=1, fwd_data=9 on the ADD above → A=9.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an RV32I/Zicsr instruction and its register
// operands into ALU operand A, operand B and an op select. The result is
// presented through a registered valid/ready output stage that has a
// one-entry skid register, so in_ready comes straight from a flop.
// Optional build macro: ALU_ISSUE_BYPASS_EN adds a forwarding port
// (fwd_valid/fwd_rd/fwd_data) that overrides rs1_data/rs2_data at accept.
module alu_issue_stage #(
  parameter int         WIDTH       = 32,   // only 32 is supported
  parameter logic [3:0] ILLEGAL_SEL = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
`ifdef ALU_ISSUE_BYPASS_EN
  input  logic             fwd_valid,
  input  logic [4:0]       fwd_rd,
  input  logic [WIDTH-1:0] fwd_data,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             out_illegal,
  output logic [4:0]       out_rd
);

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_AND  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_XOR  = 4'd4;
  localparam logic [3:0] SEL_SLL  = 4'd5;
  localparam logic [3:0] SEL_SLT  = 4'd6;
  localparam logic [3:0] SEL_SLTU = 4'd7;
  localparam logic [3:0] SEL_SRA  = 4'd8;
  localparam logic [3:0] SEL_SRL  = 4'd9;
  localparam logic [3:0] SEL_PASS = 4'd10;
  localparam logic [3:0] SEL_CSR  = 4'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             ill;
    logic [4:0]       rd;
  } entry_t;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, uimm;
  logic [WIDTH-1:0] rs1_eff, rs2_eff;
  entry_t           new_entry;

  entry_t main_q, main_d, skid_q;
  logic   main_vld_q, main_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   accept, drain, main_load, skid_load;

  assign opcode = inst_in[6:0];
  assign funct3 = inst_in[14:12];
  assign imm_i  = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s  = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b  = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                   inst_in[11:8], 1'b0};
  assign imm_u  = {inst_in[31:12], 12'b0};
  assign imm_j  = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                   inst_in[30:21], 1'b0};
  assign shamt  = {27'b0, inst_in[24:20]};
  assign uimm   = {27'b0, inst_in[19:15]};

`ifdef ALU_ISSUE_BYPASS_EN
  // A younger result still in flight overrides the stale register-file read;
  // x0 is never forwarded.
  assign rs1_eff = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == inst_in[19:15]))
                   ? fwd_data : rs1_data;
  assign rs2_eff = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == inst_in[24:20]))
                   ? fwd_data : rs2_data;
`else
  assign rs1_eff = rs1_data;
  assign rs2_eff = rs2_data;
`endif

  // Instruction decode into operands and op select; unknown encodings fall
  // through to the illegal defaults.
  always_comb begin
    new_entry     = '0;
    new_entry.sel = ILLEGAL_SEL;
    new_entry.ill = 1'b1;
    new_entry.rd  = inst_in[11:7];
    case (opcode)
      OPC_OP: begin
        new_entry.ill = 1'b0;
        new_entry.a   = rs1_eff;
        new_entry.b   = rs2_eff;
        case (funct3)
          3'b000:  new_entry.sel = inst_in[30] ? SEL_SUB : SEL_ADD;
          3'b001:  new_entry.sel = SEL_SLL;
          3'b010:  new_entry.sel = SEL_SLT;
          3'b011:  new_entry.sel = SEL_SLTU;
          3'b100:  new_entry.sel = SEL_XOR;
          3'b101:  new_entry.sel = inst_in[30] ? SEL_SRA : SEL_SRL;
          3'b110:  new_entry.sel = SEL_OR;
          default: new_entry.sel = SEL_AND;
        endcase
      end
      OPC_OPIMM: begin
        // Immediate forms have no SUB: inst[30] is an immediate bit for ADDI.
        new_entry.ill = 1'b0;
        new_entry.a   = rs1_eff;
        new_entry.b   = imm_i;
        case (funct3)
          3'b000:  new_entry.sel = SEL_ADD;
          3'b001: begin
            new_entry.sel = SEL_SLL;
            new_entry.b   = shamt;
          end
          3'b010:  new_entry.sel = SEL_SLT;
          3'b011:  new_entry.sel = SEL_SLTU;
          3'b100:  new_entry.sel = SEL_XOR;
          3'b101: begin
            new_entry.sel = inst_in[30] ? SEL_SRA : SEL_SRL;
            new_entry.b   = shamt;
          end
          3'b110:  new_entry.sel = SEL_OR;
          default: new_entry.sel = SEL_AND;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          new_entry.ill = 1'b0;
          new_entry.sel = SEL_ADD;
          new_entry.a   = rs1_eff;
          new_entry.b   = imm_i;
        end
      end
      OPC_STORE: begin
        if (!funct3[2] && funct3 != 3'b011) begin
          new_entry.ill = 1'b0;
          new_entry.sel = SEL_ADD;
          new_entry.a   = rs1_eff;
          new_entry.b   = imm_s;
        end
      end
      OPC_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          new_entry.ill = 1'b0;
          new_entry.sel = SEL_ADD;
          new_entry.a   = pc_in;
          new_entry.b   = imm_b;
        end
      end
      OPC_JAL: begin
        new_entry.ill = 1'b0;
        new_entry.sel = SEL_ADD;
        new_entry.a   = pc_in;
        new_entry.b   = imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          new_entry.ill = 1'b0;
          new_entry.sel = SEL_ADD;
          new_entry.a   = rs1_eff;
          new_entry.b   = imm_i;
        end
      end
      OPC_LUI: begin
        new_entry.ill = 1'b0;
        new_entry.sel = SEL_PASS;
        new_entry.b   = imm_u;
      end
      OPC_AUIPC: begin
        new_entry.ill = 1'b0;
        new_entry.sel = SEL_ADD;
        new_entry.a   = pc_in;
        new_entry.b   = imm_u;
      end
      OPC_SYSTEM: begin
        // Only the six CSR forms; ECALL/EBREAK and funct3=100 are illegal here.
        if (funct3[1:0] != 2'b00) begin
          new_entry.ill = 1'b0;
          new_entry.sel = SEL_CSR;
          new_entry.a   = funct3[2] ? uimm : rs1_eff;
        end
      end
      default: ;
    endcase
  end

  // Skid-buffer control: in_ready is a pure function of the skid flop, so
  // accept never depends combinationally on out_ready.
  assign in_ready  = !skid_vld_q;
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = main_vld_q && out_ready;
  // main reloads from skid when it drains, or takes the new entry when it is
  // free or draining with an empty skid; skid only fills on a stalled main.
  assign main_load = !flush && ((drain && skid_vld_q) ||
                                (accept && (!main_vld_q || drain)));
  assign skid_load = !flush && accept && main_vld_q && !drain;
  assign main_d    = skid_vld_q ? skid_q : new_entry;

  // Next-state for the two occupancy flags.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (drain && skid_vld_q) begin
      main_vld_d = 1'b1;
      skid_vld_d = 1'b0;
    end else if (drain) begin
      main_vld_d = accept;
    end else if (accept && !main_vld_q) begin
      main_vld_d = 1'b1;
    end else if (accept) begin
      skid_vld_d = 1'b1;
    end
  end

  // Occupancy flags; flush and reset both empty the stage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Output (main) data register; holds while stalled, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q.a   <= '0;
      main_q.b   <= '0;
      main_q.sel <= ILLEGAL_SEL;
      main_q.ill <= 1'b0;
      main_q.rd  <= '0;
    end else if (main_load) begin
      main_q <= main_d;
    end
  end

  // Skid data register; contents are only meaningful while skid_vld_q is set.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_q <= new_entry;
    end
  end

  assign out_valid   = main_vld_q;
  assign alu_a       = main_q.a;
  assign alu_b       = main_q.b;
  assign alu_sel     = main_q.sel;
  assign out_illegal = main_q.ill;
  assign out_rd      = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed decode vectors from a table, plus hand-written
// backpressure, flush and mid-operation reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] inst_in, pc_in, rs1_data, rs2_data, alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [4:0]  out_rd;
`ifdef ALU_ISSUE_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ALU_ISSUE_BYPASS_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .out_illegal(out_illegal), .out_rd(out_rd)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] inst, pc, rs1, rs2, a, b,
                              input logic [3:0] sel, input logic ill,
                              input logic [4:0] rd);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.a = a; v.b = b; v.sel = sel; v.ill = ill; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] r1);
    in_valid = 1'b1;
    inst_in  = inst;
    pc_in    = 32'h0;
    rs1_data = r1;
    rs2_data = 32'd7;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst_in = '0; pc_in = '0; rs1_data = '0; rs2_data = '0;
`ifdef ALU_ISSUE_BYPASS_EN
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif

    //           inst          pc            rs1           rs2           A             B             sel    ill  rd
    vecs.push_back(mk(32'h002081B3, 32'h0,    32'd5,        32'd7,        32'd5,        32'd7,        4'd0,  1'b0, 5'd3));
    vecs.push_back(mk(32'h402081B3, 32'h0,    32'd5,        32'd7,        32'd5,        32'd7,        4'd1,  1'b0, 5'd3));
    vecs.push_back(mk(32'h4030D193, 32'h0,    32'h80000000, 32'd7,        32'h80000000, 32'd3,        4'd8,  1'b0, 5'd3));
    vecs.push_back(mk(32'h123450B7, 32'h0,    32'd5,        32'd7,        32'd0,        32'h12345000, 4'd10, 1'b0, 5'd1));
    vecs.push_back(mk(32'h34015073, 32'h0,    32'd5,        32'd7,        32'd2,        32'd0,        4'd11, 1'b0, 5'd0));
    vecs.push_back(mk(32'h00000000, 32'h0,    32'd5,        32'd7,        32'd0,        32'd0,        4'hF,  1'b1, 5'd0));
    vecs.push_back(mk(32'h00000073, 32'h0,    32'd5,        32'd7,        32'd0,        32'd0,        4'hF,  1'b1, 5'd0));
    vecs.push_back(mk(32'hFFF30293, 32'h0,    32'd10,       32'd7,        32'd10,       32'hFFFFFFFF, 4'd0,  1'b0, 5'd5));
    vecs.push_back(mk(32'hFE20AE23, 32'h0,    32'h100,      32'd7,        32'h100,      32'hFFFFFFFC, 4'd0,  1'b0, 5'd28));
    vecs.push_back(mk(32'hFE208CE3, 32'h1000, 32'd1,        32'd7,        32'h1000,     32'hFFFFFFF8, 4'd0,  1'b0, 5'd25));
    vecs.push_back(mk(32'h001000EF, 32'h2000, 32'd1,        32'd7,        32'h2000,     32'h800,      4'd0,  1'b0, 5'd1));
    vecs.push_back(mk(32'hFFFFF197, 32'h3000, 32'd1,        32'd7,        32'h3000,     32'hFFFFF000, 4'd0,  1'b0, 5'd3));
    vecs.push_back(mk(32'h0020B1B3, 32'h0,    32'd4,        32'd9,        32'd4,        32'd9,        4'd7,  1'b0, 5'd3));
    vecs.push_back(mk(32'h0020E1B3, 32'h0,    32'd4,        32'd9,        32'd4,        32'd9,        4'd3,  1'b0, 5'd3));
    vecs.push_back(mk(32'h0020F1B3, 32'h0,    32'd4,        32'd9,        32'd4,        32'd9,        4'd2,  1'b0, 5'd3));
    vecs.push_back(mk(32'h0020D1B3, 32'h0,    32'd4,        32'd9,        32'd4,        32'd9,        4'd9,  1'b0, 5'd3));
    vecs.push_back(mk(32'h4020D1B3, 32'h0,    32'd4,        32'd9,        32'd4,        32'd9,        4'd8,  1'b0, 5'd3));
    vecs.push_back(mk(32'h40008093, 32'h0,    32'd6,        32'd9,        32'd6,        32'h400,      4'd0,  1'b0, 5'd1));
    vecs.push_back(mk(32'h01F09193, 32'h0,    32'd6,        32'd9,        32'd6,        32'd31,       4'd5,  1'b0, 5'd3));
    vecs.push_back(mk(32'h300322F3, 32'h0,    32'hABCD,     32'd9,        32'hABCD,     32'd0,        4'd11, 1'b0, 5'd5));
    vecs.push_back(mk(32'hFFC100E7, 32'h0,    32'h4000,     32'd9,        32'h4000,     32'hFFFFFFFC, 4'd0,  1'b0, 5'd1));
    vecs.push_back(mk(32'h0101A203, 32'h0,    32'h8000,     32'd9,        32'h8000,     32'd16,       4'd0,  1'b0, 5'd4));
    vecs.push_back(mk(32'hFFF0C093, 32'h0,    32'd3,        32'd9,        32'd3,        32'hFFFFFFFF, 4'd4,  1'b0, 5'd1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_alu_a",     alu_a, 0);
    chk("rst_alu_b",     alu_b, 0);
    chk("rst_alu_sel",   alu_sel, 4'hF);
    chk("rst_illegal",   out_illegal, 0);
    chk("rst_rd",        out_rd, 0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table, streamed back to back with out_ready held high
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      inst_in  = vecs[i].inst;
      pc_in    = vecs[i].pc;
      rs1_data = vecs[i].rs1;
      rs2_data = vecs[i].rs2;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_a", i), alu_a, vecs[i].a);
      chk($sformatf("vec%0d_b", i), alu_b, vecs[i].b);
      chk($sformatf("vec%0d_sel", i), alu_sel, vecs[i].sel);
      chk($sformatf("vec%0d_ill", i), out_illegal, vecs[i].ill);
      chk($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("table_drained", out_valid, 0);

    // Backpressure: two accepts fill main+skid, third is held upstream
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h002080B3, 32'd11);
    @(posedge clk); #1;
    chk("bp_valid1", out_valid, 1);
    chk("bp_ready1", in_ready, 1);
    @(negedge clk);
    drive(32'h00208133, 32'd22);
    @(posedge clk); #1;
    chk("bp_ready2", in_ready, 0);
    chk("bp_hold_rd", out_rd, 1);
    @(negedge clk);
    drive(32'h002081B3, 32'd33);
    @(posedge clk); #1;
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_hold_a", alu_a, 32'd11);
    chk("bp_hold_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second_rd", out_rd, 2);
    chk("bp_second_a", alu_a, 32'd22);
    chk("bp_ready_back", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_third_valid", out_valid, 1);
    chk("bp_third_rd", out_rd, 3);
    chk("bp_third_a", alu_a, 32'd33);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);

    // Flush with main and skid full and a new input in the same cycle
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h00208233, 32'd44);
    @(posedge clk);
    @(negedge clk);
    drive(32'h002082B3, 32'd55);
    @(posedge clk); #1;
    chk("fl_skid_full", in_ready, 0);
    @(negedge clk);
    flush = 1'b1;
    drive(32'h00208333, 32'd66);
    @(posedge clk); #1;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("fl_gone%0d", k), out_valid, 0);
    end
    @(negedge clk);
    drive(32'h002083B3, 32'd77);
    @(posedge clk); #1;
    chk("fl_after_rd", out_rd, 7);
    chk("fl_after_a", alu_a, 32'd77);
    @(negedge clk);
    in_valid = 1'b0;

    // Reset while the output register holds an entry
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd5);
    @(posedge clk); #1;
    chk("mr_loaded", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_a", alu_a, 0);
    chk("mr_b", alu_b, 0);
    chk("mr_sel", alu_sel, 4'hF);
    chk("mr_rd", out_rd, 0);
    chk("mr_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef ALU_ISSUE_BYPASS_EN
    // Forwarding onto rs1 only, then onto both sources
    @(negedge clk);
    fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'd9;
    drive(32'h002081B3, 32'd5);
    @(posedge clk); #1;
    chk("byp_a", alu_a, 32'd9);
    chk("byp_b", alu_b, 32'd7);
    @(negedge clk);
    drive(32'h001081B3, 32'd5);
    @(posedge clk); #1;
    chk("byp_both_a", alu_a, 32'd9);
    chk("byp_both_b", alu_b, 32'd9);
    @(negedge clk);
    fwd_rd = 5'd0;
    drive(32'h000001B3, 32'd5);
    @(posedge clk); #1;
    chk("byp_x0_a", alu_a, 32'd5);
    @(negedge clk);
    in_valid = 1'b0; fwd_valid = 1'b0;
`endif

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
